// File: rtl/mds_inv_if.sv
// Handshake bundle for the inverse-MDS block: one z word in, one y vector out.
// Both directions use valid/ready: a transfer happens on a rising clk edge
// where valid and ready are both 1; valid, once raised, holds its payload
// stable until that edge, and ready may be sampled freely without side effect.
interface mds_inv_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] z;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  y0;
   logic [7:0]  y1;
   logic [7:0]  y2;
   logic [7:0]  y3;
   logic [1:0]  dbg_state;

   modport master (
      output in_valid, z, out_ready,
      input  in_ready, out_valid, y0, y1, y2, y3, dbg_state
   );

   modport slave (
      input  in_valid, z, out_ready,
      output in_ready, out_valid, y0, y1, y2, y3, dbg_state
   );
endinterface

// File: rtl/mds_inv.sv
// Inverse Twofish MDS: y = Minv * z over GF(2^8) mod 0x169.
// One shared multiplier walks the 16 matrix terms (one per cycle), folding
// each product into the accumulator of its row; the finished vector is
// registered on y0..y3 and held until the next result replaces it.
module mds_inv (
   input logic   clk,
   input logic   rst,
   mds_inv_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nx;
   logic [3:0]  k;
   logic [31:0] zreg;
   logic [7:0]  acc [4];
   logic [7:0]  y_q [4];
   logic [1:0]  row;
   logic [1:0]  col;
   logic [7:0]  coef;
   logic [7:0]  zbyte;
   logic [7:0]  prod;
   logic        in_ready_w;
   logic        out_valid_w;

   // Shift-and-add multiply; x^8 folds back as x^6+x^5+x^3+1 (0x69).
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] s;
      p = 8'h00;
      s = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ s;
         s = s[7] ? ({s[6:0], 1'b0} ^ 8'h69) : {s[6:0], 1'b0};
      end
      return p;
   endfunction

   // Inverse of the MDS matrix, indexed {row, col}; entries precomputed.
   function automatic logic [7:0] minv_rom(input logic [3:0] idx);
      logic [7:0] c;
      c = 8'h00;
      case (idx)
         4'h0: c = 8'hBB;  4'h1: c = 8'hC4;  4'h2: c = 8'hED;  4'h3: c = 8'h89;
         4'h4: c = 8'h1B;  4'h5: c = 8'hED;  4'h6: c = 8'hBF;  4'h7: c = 8'h7B;
         4'h8: c = 8'hF2;  4'h9: c = 8'h89;  4'hA: c = 8'h7B;  4'hB: c = 8'h89;
         4'hC: c = 8'h32;  4'hD: c = 8'hBB;  4'hE: c = 8'h1B;  4'hF: c = 8'hF2;
         default: c = 8'h00;
      endcase
      return c;
   endfunction

   assign row = k[3:2];
   assign col = k[1:0];

   // Select this step's coefficient and captured z byte, then multiply.
   always_comb begin
      zbyte = 8'h00;
      coef  = minv_rom(k);
      case (col)
         2'd0: zbyte = zreg[31:24];
         2'd1: zbyte = zreg[23:16];
         2'd2: zbyte = zreg[15:8];
         2'd3: zbyte = zreg[7:0];
         default: zbyte = 8'h00;
      endcase
      prod = gf_mul(coef, zbyte);
   end

   // Next-state and handshake outputs; ready and valid are decoded from state.
   always_comb begin
      state_nx    = state;
      in_ready_w  = 1'b0;
      out_valid_w = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready_w = 1'b1;
            if (bus.in_valid) state_nx = MUL;
         end
         MUL: begin
            if (k == 4'd15) state_nx = DONE;
         end
         DONE: begin
            out_valid_w = 1'b1;
            if (bus.out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // State register; reset wins over any handshake in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Datapath: capture z, accumulate one term per MUL cycle, publish at k=15.
   always_ff @(posedge clk) begin
      if (rst) begin
         k    <= 4'd0;
         zreg <= 32'h0;
         for (int i = 0; i < 4; i++) begin
            acc[i] <= 8'h00;
            y_q[i] <= 8'h00;
         end
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  zreg <= bus.z;
                  k    <= 4'd0;
                  for (int i = 0; i < 4; i++) acc[i] <= 8'h00;
               end
            end
            MUL: begin
               acc[row] <= acc[row] ^ prod;
               k        <= k + 4'd1;
               if (k == 4'd15) begin
                  // Row 3 receives its last term on this same edge.
                  y_q[0] <= acc[0];
                  y_q[1] <= acc[1];
                  y_q[2] <= acc[2];
                  y_q[3] <= acc[3] ^ prod;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_w;
   assign bus.out_valid = out_valid_w;
   assign bus.y0        = y_q[0];
   assign bus.y1        = y_q[1];
   assign bus.y2        = y_q[2];
   assign bus.y3        = y_q[3];
   assign bus.dbg_state = state;

endmodule

// File: tb/tb_mds_inv.sv
// Bench for mds_inv: random y vectors are pushed through a forward MDS model
// and the block must hand the same y back, with latency, hold, exclusivity
// and reset behaviour checked on every cycle by one compare process.
module tb_mds_inv;

   logic clk = 1'b0;
   logic rst = 1'b1;

   mds_inv_if bus();

   mds_inv dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int          errors = 0;
   int          checks = 0;
   logic [31:0] exp_q[$];
   logic [31:0] cur_exp = 32'h0;
   logic [31:0] y_hold = 32'h0;
   int          lat_cnt = 0;
   bit          lat_on = 1'b0;

   localparam logic [7:0] MDS [4][4] = '{
      '{8'h01, 8'hEF, 8'h5B, 8'h5B},
      '{8'h5B, 8'hEF, 8'hEF, 8'h01},
      '{8'hEF, 8'h5B, 8'h01, 8'hEF},
      '{8'hEF, 8'h01, 8'hEF, 8'h5B}
   };

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out (t=%0t)", name, $time);
   endtask

   // ---------------- reference model ----------------
   // Carry-less product, then polynomial reduction by 0x169.
   function automatic logic [7:0] gf_mul_ref(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = 16'h0;
      for (int i = 0; i < 8; i++)
         if (b[i]) p = p ^ (16'(a) << i);
      for (int i = 15; i >= 8; i--)
         if (p[i]) p = p ^ (16'h169 << (i - 8));
      return p[7:0];
   endfunction

   // Forward MDS: z_i = XOR_j M[i][j] * y_j, bytes packed most significant first.
   function automatic logic [31:0] mds_model(input logic [31:0] yv);
      logic [31:0] zv;
      logic [7:0]  s;
      zv = 32'h0;
      for (int i = 0; i < 4; i++) begin
         s = 8'h00;
         for (int j = 0; j < 4; j++)
            s = s ^ gf_mul_ref(MDS[i][j], yv[31 - 8*j -: 8]);
         zv[31 - 8*i -: 8] = s;
      end
      return zv;
   endfunction

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      logic [31:0] yv;
      yv = {bus.y0, bus.y1, bus.y2, bus.y3};
      if (rst) begin
         exp_q.delete();
         y_hold = 32'h0;
         lat_on = 1'b0;
      end else begin
         chk("ready_valid_exclusive", 32'(bus.in_ready & bus.out_valid), 32'h0);
         if (lat_on) lat_cnt++;
         if (bus.out_valid) begin
            if (lat_on) begin
               chk("latency", lat_cnt, 17);
               lat_on = 1'b0;
            end
            if (exp_q.size() == 0) begin
               timeout_fail("unexpected_result");
            end else begin
               chk("result_y", yv, exp_q[0]);
               if (bus.out_ready) y_hold = exp_q.pop_front();
            end
         end else begin
            chk("y_hold", yv, y_hold);
         end
         if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back(cur_exp);
            lat_on  = 1'b1;
            lat_cnt = 0;
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Present z until accepted; returns at posedge+1 after the accepting edge.
   task automatic accept_word(input logic [31:0] zv, input logic [31:0] yexp, output bit ok);
      ok            = 1'b0;
      cur_exp       = yexp;
      bus.z         = zv;
      bus.in_valid  = 1'b1;
      for (int t = 0; t < 50 && !ok; t++) begin
         @(negedge clk);
         if (bus.in_ready) ok = 1'b1;
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      if (!ok) timeout_fail("accept");
   endtask

   // Wait for the result; hold out_ready low for 'hold' DONE cycles, or with
   // junk set, scramble in_valid/z/out_ready while the word is in flight.
   task automatic finish_word(input int hold, input bit junk);
      int dcnt;
      bit got;
      dcnt = 0;
      got  = 1'b0;
      for (int t = 0; t < 100 && !got; t++) begin
         if (junk) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.z         = $urandom;
            bus.out_ready = 1'($urandom_range(0, 1));
         end else begin
            bus.in_valid  = 1'b0;
            bus.out_ready = (dcnt >= hold);
         end
         @(negedge clk);
         if (bus.out_valid) begin
            if (bus.out_ready) got = 1'b1;
            else dcnt++;
         end
         @(posedge clk); #1;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      if (!got) timeout_fail("result");
   endtask

   task automatic drive_vec(input logic [31:0] zv, input logic [31:0] yexp,
                            input int hold, input bit junk);
      bit ok;
      bus.out_ready = (hold == 0);
      accept_word(zv, yexp, ok);
      if (ok) finish_word(hold, junk);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] yr;
      bit          ok;
      bus.in_valid  = 1'b0;
      bus.z         = 32'h0;
      bus.out_ready = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state with no stimulus.
      @(negedge clk);
      chk("reset_in_ready", 32'(bus.in_ready), 32'h1);
      chk("reset_out_valid", 32'(bus.out_valid), 32'h0);
      chk("reset_y", {bus.y0, bus.y1, bus.y2, bus.y3}, 32'h0);
      chk("reset_dbg_state", 32'(bus.dbg_state), 32'h0);
      @(posedge clk); #1;

      // Pin the model against hand-worked values.
      chk("model_mul_5b_5b", 32'(gf_mul_ref(8'h5B, 8'h5B)), 32'hA3);
      chk("model_mul_ef_ef", 32'(gf_mul_ref(8'hEF, 8'hEF)), 32'hF9);
      chk("model_mul_1d_bb", 32'(gf_mul_ref(8'h1D, 8'hBB)), 32'h01);
      chk("model_e0", mds_model(32'h01000000), 32'h015BEFEF);
      chk("model_e1", mds_model(32'h00010000), 32'hEFEF5B01);
      chk("model_e2", mds_model(32'h00000100), 32'h5BEF01EF);

      // Basis vectors and zero, out_ready held high.
      drive_vec(32'h015BEFEF, 32'h01000000, 0, 1'b0);
      drive_vec(32'hEFEF5B01, 32'h00010000, 0, 1'b0);
      drive_vec(32'h00000000, 32'h00000000, 0, 1'b0);
      drive_vec(32'h5BEF01EF, 32'h00000100, 0, 1'b0);
      drive_vec(mds_model(32'h00000001), 32'h00000001, 0, 1'b0);

      // Backpressure: ten DONE cycles with out_ready low.
      yr = $urandom;
      drive_vec(mds_model(yr), yr, 10, 1'b0);

      // Input noise during MUL/DONE must not disturb the captured word.
      yr = $urandom;
      drive_vec(mds_model(yr), yr, 0, 1'b1);

      // Reset in MUL cycle 8 aborts the word; the next one works normally.
      bus.out_ready = 1'b1;
      accept_word(32'h12345678, 32'h0, ok);
      repeat (7) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("abort_in_ready", 32'(bus.in_ready), 32'h1);
      chk("abort_out_valid", 32'(bus.out_valid), 32'h0);
      chk("abort_y", {bus.y0, bus.y1, bus.y2, bus.y3}, 32'h0);
      @(posedge clk); #1;
      drive_vec(32'hEFEF5B01, 32'h00010000, 0, 1'b0);

      // Reset beats a simultaneous handshake: nothing may come out.
      bus.in_valid = 1'b1;
      bus.z        = 32'hA5A5A5A5;
      rst          = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      bus.in_valid = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_priority_in_ready", 32'(bus.in_ready), 32'h1);
      @(posedge clk); #1;

      // Random round trips with random backpressure, noise and idle gaps.
      for (int n = 0; n < 300; n++) begin
         yr = $urandom;
         drive_vec(mds_model(yr), yr, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end

      repeat (3) @(posedge clk);
      #1;
      chk("queue_drained", 32'(exp_q.size()), 32'h0);

      // ---------------- final report ----------------
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1);
   end

endmodule

// File: doc/mds_inv.md
MDS_INV -- requirements
Module: mds_inv

Interface
Parameters: none.
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 in_valid  in  1  z word presented.
REQ-005 in_ready  out  1  block can accept a z word.
REQ-006 z  in  32  MDS-domain word; z[31:24]=z0, z[23:16]=z1, z[15:8]=z2, z[7:0]=z3.
REQ-007 out_valid  out  1  y0..y3 hold a result.
REQ-008 out_ready  in  1  consumer accepts the result.
REQ-009 y0, y1, y2, y3  out  8 each  recovered byte vector.

Function
REQ-010 The block SHALL compute y = M^-1 * z over GF(2^8) with primitive polynomial x^8+x^6+x^5+x^3+1 (0x169).
- M is the Twofish MDS matrix, rows {01,EF,5B,5B}, {5B,EF,EF,01}, {EF,5B,01,EF}, {EF,01,EF,5B}.
- Forward convention: z_i = XOR over j of M[i][j]*y_j.
REQ-011 The 16 coefficients of M^-1 SHALL be fixed constants derived offline and held in a 16-entry combinational ROM indexed {row, col}.
REQ-012 The datapath SHALL use exactly one 8x8 GF(2^8) multiplier (0x169 reduction) plus four 8-bit XOR accumulators acc0..acc3.
REQ-013 The FSM SHALL have states IDLE, MUL, DONE.
REQ-014 IDLE behaviour:
- in_ready=1.
- On in_valid&&in_ready: capture z into an internal register, clear acc0..acc3, set k=0, go to MUL.
REQ-015 MUL behaviour:
- Each cycle: row=k[3:2], col=k[1:0].
- acc[row] <= acc[row] ^ gfmul(Minv[row][col], zreg byte col).
- k increments 0..15.
- After the k=15 update, copy acc0..acc3 to y0..y3 and go to DONE.
REQ-016 Latency SHALL be exactly 17 cycles from the accepting edge to the first cycle with out_valid=1.
REQ-017 DONE behaviour:
- out_valid=1; y0..y3 stable.
- On out_ready=1: go to IDLE with out_valid=0 on the next cycle.
REQ-018 in_ready SHALL be 0 in MUL and DONE; in_valid there is ignored and z is not sampled.
REQ-019 in_ready and out_valid SHALL never both be 1; throughput is at most one word per 18 cycles.
REQ-020 Changes on z after capture SHALL NOT affect the result.
REQ-021 out_ready while out_valid=0 SHALL have no effect.
REQ-022 y0..y3 SHALL hold their last result through IDLE and MUL until overwritten at the end of the next MUL.
REQ-023 k SHALL be 4 bits; wrap from 15 to 0 occurs only on the MUL->DONE transition.
REQ-024 The result SHALL satisfy the round-trip property: mds(y0..y3) == z for all 2^32 inputs.

Reset
REQ-025 On rst=1 at a clock edge the block SHALL:
- enter IDLE;
- clear k, zreg and acc0..acc3;
- drive y0..y3=00, out_valid=0, in_ready=1.
REQ-026 Reset SHALL take priority over any simultaneous handshake.
REQ-027 Reset asserted in MUL or DONE SHALL abort the operation with no result delivered.
REQ-028 The first post-reset handshake SHALL be accepted normally.

Verification
REQ-029 Out of reset, no stimulus -> in_ready=1, out_valid=0, y0..y3=00.
REQ-030 Basis vectors, out_ready held high:
- z=0x015BEFEF -> y=(01,00,00,00) with out_valid exactly 17 cycles after accept.
- z=0xEFEF5B01 -> y=(00,01,00,00).
REQ-031 z=0x00000000 -> y=(00,00,00,00); z=0x5BEF01EF -> y=(00,00,01,00).
REQ-032 Backpressure:
- Hold out_ready=0 for 10 cycles in DONE -> y stable, in_ready=0 throughout.
- Toggling z and in_valid during MUL/DONE -> no effect on the result.
REQ-033 Reset mid-operation:
- Assert rst at MUL cycle 8 -> IDLE next cycle with y=00.
- A following z=0xEFEF5B01 -> y=(00,01,00,00).
REQ-034 Random round-trip: 10^5 random y vectors -> feed through the existing mds block into mds_inv -> the original y0..y3 is recovered every time.
